mem_port_arbiter: RTL and testbench

Arbiter and sequencer for the single-port unified memory of the multicycle RISC core. It shares the port between three requesters: instruction fetch, data load/store and the host/debug port. Each access is a request/acknowledge transaction, and the block drives the memory port cycle by cycle. It sits between the Controller-driven datapath (fetch and load/store addresses) and the memory macro, so the Controller sees a variable-latency memory.

---
 rtl/mem_port_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and sequencer sharing one single-port memory between
// instruction fetch, data load/store and the host/debug port.
module mem_port_arbiter #(
    parameter int unsigned AW     = 8,
    parameter int unsigned DW     = 16,
    parameter int unsigned RD_LAT = 1
) (
    input  logic          clk,
    input  logic          Rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    input  logic          h_req,
    input  logic          h_we,
    input  logic [AW-1:0] h_addr,
    input  logic [DW-1:0] h_wdata,
    output logic          h_ack,
    output logic [DW-1:0] rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic [1:0]    gnt_id
);

    localparam int unsigned CW   = 2;
    localparam int unsigned NREQ = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    logic [1:0]      r_last;
    logic [1:0]      r_id;
    logic [NREQ-1:0] r_mask;
    logic [CW-1:0]   r_cnt;

    logic [NREQ-1:0] w_act;
    logic            w_any;
    logic [1:0]      w_win;
    logic            w_we;
    logic [AW-1:0]   w_addr;
    logic [DW-1:0]   w_wdata;

    // Round-robin pick starting one past the last grant; the masked id sits out.
    always_comb begin
        w_act = {h_req, d_req, if_req} & ~r_mask;
        w_any = |w_act;
        w_win = 2'd0;
        case (r_last)
            2'd0: begin
                if (w_act[1])      w_win = 2'd1;
                else if (w_act[2]) w_win = 2'd2;
                else               w_win = 2'd0;
            end
            2'd1: begin
                if (w_act[2])      w_win = 2'd2;
                else if (w_act[0]) w_win = 2'd0;
                else               w_win = 2'd1;
            end
            default: begin
                if (w_act[0])      w_win = 2'd0;
                else if (w_act[1]) w_win = 2'd1;
                else               w_win = 2'd2;
            end
        endcase
    end

    // Winner's request payload; fetch is always a read.
    always_comb begin
        w_we    = 1'b0;
        w_addr  = if_addr;
        w_wdata = '0;
        case (w_win)
            2'd0: begin
                w_we    = 1'b0;
                w_addr  = if_addr;
                w_wdata = '0;
            end
            2'd1: begin
                w_we    = d_we;
                w_addr  = d_addr;
                w_wdata = d_wdata;
            end
            default: begin
                w_we    = h_we;
                w_addr  = h_addr;
                w_wdata = h_wdata;
            end
        endcase
    end

    // mem_addr/mem_wdata/mem_we double as the latched copy of the granted request.
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            r_state   <= S_IDLE;
            r_last    <= 2'd2;
            r_id      <= 2'd0;
            r_mask    <= '0;
            r_cnt     <= '0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            h_ack     <= 1'b0;
            rdata     <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            gnt_id    <= 2'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_mask <= '0;
                    if (w_any) begin
                        r_state   <= S_ISSUE;
                        r_id      <= w_win;
                        r_last    <= w_win;
                        gnt_id    <= w_win;
                        busy      <= 1'b1;
                        mem_en    <= 1'b1;
                        mem_we    <= w_we;
                        mem_addr  <= w_addr;
                        mem_wdata <= w_wdata;
                    end
                end
                S_ISSUE: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    if (mem_we) begin
                        r_state <= S_DONE;
                        if_ack  <= (r_id == 2'd0);
                        d_ack   <= (r_id == 2'd1);
                        h_ack   <= (r_id == 2'd2);
                    end else begin
                        r_state <= S_WAIT;
                        r_cnt   <= CW'(RD_LAT - 1);
                    end
                end
                S_WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else begin
                        rdata   <= mem_rdata;
                        r_state <= S_DONE;
                        if_ack  <= (r_id == 2'd0);
                        d_ack   <= (r_id == 2'd1);
                        h_ack   <= (r_id == 2'd2);
                    end
                end
                S_DONE: begin
                    // Requester drops req on this edge; mask covers the lingering cycle.
                    if_ack  <= 1'b0;
                    d_ack   <= 1'b0;
                    h_ack   <= 1'b0;
                    busy    <= 1'b0;
                    r_mask  <= NREQ'(3'b001 << r_id);
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a transaction-level model predicts
// grants, memory strobes and acks; a monitor compares whatever the DUT shows.
module tb_mem_port_arbiter;

    localparam int AW     = 8;
    localparam int DW     = 16;
    localparam int RD_LAT = 3;
    localparam int DEPTH  = 1 << AW;
    localparam int LIMIT  = 100;

    typedef struct {
        int            cyc;
        int            id;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          Rst;
    logic          if_req, d_req, h_req, d_we, h_we;
    logic [AW-1:0] if_addr, d_addr, h_addr;
    logic [DW-1:0] d_wdata, h_wdata;
    logic          if_ack, d_ack, h_ack;
    logic [DW-1:0] rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          busy;
    logic [1:0]    gnt_id;
    logic [2:0]    ack_v;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int n_ack [3];

    exp_t iss_q [$];
    exp_t ack_q [$];
    logic [DW-1:0] ref_mem [int];
    int   m_from = 0, m_to = 0;

    mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .Rst(Rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata), .h_ack(h_ack),
        .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .gnt_id(gnt_id)
    );

    assign ack_v = {h_ack, d_ack, if_ack};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return DW'({a, a}) ^ 16'h5A5A;
    endfunction

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return init_val(a);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Memory macro: read data appears RD_LAT cycles after the strobe, garbage otherwise.
    logic [DW-1:0] mem_arr  [DEPTH];
    bit            wr_valid [DEPTH];
    logic [DW-1:0] rd_pipe  [RD_LAT];
    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            mem_arr[mem_addr]  <= mem_wdata;
            wr_valid[mem_addr] <= 1'b1;
        end
        rd_pipe[0] <= (mem_en && !mem_we) ?
                      (wr_valid[mem_addr] ? mem_arr[mem_addr] : init_val(mem_addr)) :
                      DW'($urandom);
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[RD_LAT-1];

    // Transaction-level reference: one grant per free IDLE cycle, fixed durations.
    initial begin : model
        int            t_free, mask_cyc, mask_id, m_last, win, c, dur;
        logic [2:0]    act;
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] wd, last_rdata;
        exp_t          e;
        t_free = 0; mask_cyc = -1; mask_id = 0; m_last = 2; last_rdata = '0;
        forever begin
            @(negedge clk);
            if (Rst) begin
                iss_q.delete(); ack_q.delete();
                t_free = 0; mask_cyc = -1; mask_id = 0; m_last = 2; last_rdata = '0;
                m_from = 0; m_to = 0;
            end else if (cyc >= t_free) begin
                act = {h_req, d_req, if_req};
                if (cyc == mask_cyc) act[2'(mask_id)] = 1'b0;
                if (act != 3'b000) begin
                    win = -1;
                    for (int k = 0; k < 3; k++) begin
                        c = (m_last + 1 + k) % 3;
                        if (win < 0 && act[2'(c)]) win = c;
                    end
                    case (win)
                        0:       begin we = 1'b0; a = if_addr; wd = '0;      end
                        1:       begin we = d_we; a = d_addr;  wd = d_wdata; end
                        default: begin we = h_we; a = h_addr;  wd = h_wdata; end
                    endcase
                    dur = we ? 3 : 3 + RD_LAT;
                    e.cyc = cyc + 1; e.id = win; e.we = we; e.addr = a; e.data = wd;
                    iss_q.push_back(e);
                    if (we) ref_mem[int'(a)] = wd;
                    else    last_rdata = ref_rd(a);
                    e.cyc = cyc + dur - 1; e.data = last_rdata;
                    ack_q.push_back(e);
                    m_from = cyc; m_to = cyc + dur - 1;
                    t_free = cyc + dur; mask_cyc = cyc + dur; mask_id = win; m_last = win;
                end
            end
        end
    end

    // Monitor: pops a prediction whenever the DUT strobes memory or acks.
    initial begin : monitor
        exp_t e;
        int   aid;
        forever begin
            @(negedge clk);
            if (!Rst) begin
                chk("ack_onehot", 32'($countones(ack_v) <= 1), 32'd1);
                chk("ack_with_mem_en", 32'((ack_v != 3'b000) && mem_en), 32'd0);
                chk("busy", 32'(busy), 32'(cyc > m_from && cyc <= m_to));
                if (mem_en) begin
                    chk("issue_expected", 32'(iss_q.size() > 0), 32'd1);
                    if (iss_q.size() > 0) begin
                        e = iss_q.pop_front();
                        chk("issue_cycle", cyc, e.cyc);
                        chk("issue_gnt_id", 32'(gnt_id), e.id);
                        chk("issue_we", 32'(mem_we), 32'(e.we));
                        chk("issue_addr", 32'(mem_addr), 32'(e.addr));
                        if (e.we) chk("issue_wdata", 32'(mem_wdata), 32'(e.data));
                    end
                end
                if (ack_v != 3'b000) begin
                    aid = if_ack ? 0 : (d_ack ? 1 : 2);
                    n_ack[aid]++;
                    chk("ack_expected", 32'(ack_q.size() > 0), 32'd1);
                    if (ack_q.size() > 0) begin
                        e = ack_q.pop_front();
                        chk("ack_cycle", cyc, e.cyc);
                        chk("ack_id", aid, e.id);
                        chk("ack_gnt_id", 32'(gnt_id), e.id);
                        chk("ack_rdata", 32'(rdata), 32'(e.data));
                    end
                end
            end
        end
    end

    // Requester: call at posedge+1; holds req until ack, optionally one cycle longer.
    task automatic do_req(input int id, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input bit hold);
        int k;
        case (id)
            0:       begin if_addr = a; if_req = 1'b1; end
            1:       begin d_we = we; d_addr = a; d_wdata = wd; d_req = 1'b1; end
            default: begin h_we = we; h_addr = a; h_wdata = wd; h_req = 1'b1; end
        endcase
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!ack_v[2'(id)] && k < LIMIT);
        chk($sformatf("req%0d_acked", id), 32'(ack_v[2'(id)]), 32'd1);
        @(posedge clk);
        if (hold) @(posedge clk);
        #1;
        case (id)
            0:       if_req = 1'b0;
            1:       d_req  = 1'b0;
            default: h_req  = 1'b0;
        endcase
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1 Rst = 1'b0;
    endtask

    task automatic rand_driver(input int id, input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 4)) @(posedge clk);
            if ($urandom_range(0, 4) != 0) #1;
            else begin @(posedge clk); #1; end
            do_req(id, (id == 0) ? 1'b0 : 1'($urandom_range(0, 1)),
                   AW'($urandom_range(0, 15)), DW'($urandom),
                   ($urandom_range(0, 3) == 0));
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        int base, k;
        n_ack[0] = 0; n_ack[1] = 0; n_ack[2] = 0;
        Rst = 1'b1;
        if_req = 0; d_req = 0; h_req = 0; d_we = 0; h_we = 0;
        if_addr = '0; d_addr = '0; h_addr = '0; d_wdata = '0; h_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_acks", 32'(ack_v), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_gnt_id", 32'(gnt_id), 32'd0);
        @(posedge clk);
        #1 Rst = 1'b0;

        // Data write then fetch read of the same word.
        do_req(1, 1'b1, 8'h10, 16'hBEEF, 1'b0);
        do_req(0, 1'b0, 8'h10, '0, 1'b0);
        chk("fetch_rdata_beef", 32'(rdata), 32'h0000BEEF);

        // All three at once, twice, starting from reset priority.
        do_reset();
        repeat (2) begin
            fork
                do_req(0, 1'b0, 8'h10, '0, 1'b0);
                do_req(1, 1'b1, 8'h20, 16'h1234, 1'b0);
                do_req(2, 1'b0, 8'h10, '0, 1'b0);
            join
        end

        // Lingering request one cycle after its ack.
        do_req(1, 1'b0, 8'h20, '0, 1'b1);
        repeat (4) @(posedge clk);
        #1;

        // Reset while a host read waits on the memory.
        fork
            do_req(2, 1'b0, 8'h11, '0, 1'b0);
            begin
                k = 0;
                do begin
                    @(negedge clk);
                    k++;
                end while (!mem_en && k < LIMIT);
                chk("rst_test_issue", 32'(mem_en), 32'd1);
                @(negedge clk);
                chk("rst_test_rdata_before", 32'(rdata), 32'h00001234);
                #1 Rst = 1'b1;
                #1;
                chk("midrst_mem_en", 32'(mem_en), 32'd0);
                chk("midrst_busy", 32'(busy), 32'd0);
                chk("midrst_h_ack", 32'(h_ack), 32'd0);
                chk("midrst_rdata", 32'(rdata), 32'd0);
                @(negedge clk);
                @(posedge clk);
                #1 Rst = 1'b0;
            end
        join

        // Continuous fetch must not starve the host.
        fork
            repeat (6) do_req(0, 1'b0, AW'($urandom_range(0, 255)), '0, 1'b0);
            begin
                @(posedge clk);
                #1;
                base = n_ack[0];
                do_req(2, 1'b1, 8'h30, 16'hCAFE, 1'b0);
                chk("host_not_starved", 32'((n_ack[0] - base) <= 2), 32'd1);
            end
        join

        // Randomized contention.
        fork
            rand_driver(0, 25);
            rand_driver(1, 25);
            rand_driver(2, 25);
        join

        repeat (20) @(negedge clk);
        chk("issue_queue_drained", iss_q.size(), 32'd0);
        chk("ack_queue_drained", ack_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
